// File: rtl/bram_port_arbiter_pkg.sv
// rtl/bram_port_arbiter_pkg.sv - shared BRAM port constants, request payload type and lock states
package bram_port_arbiter_pkg;

  localparam int DEF_BRAM_ADDR_WIDTH = 32;
  localparam int DEF_BRAM_DATA_WIDTH = 128;
  localparam int DEF_BYTES_PER_WIDTH = DEF_BRAM_DATA_WIDTH / 8;
  localparam int LOCK_TIMER_WIDTH    = 8;

  typedef struct packed {
    logic [DEF_BRAM_ADDR_WIDTH-1:0] addr;
    logic [DEF_BYTES_PER_WIDTH-1:0] we;
    logic [DEF_BRAM_DATA_WIDTH-1:0] wdata;
    logic                           lock;
  } req_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// rtl/bram_port_arbiter_rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module bram_port_arbiter_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [N-1:0] upper;
  logic [N-1:0] pick;

  // Requests at or above ptr win; otherwise wrap around to the lowest set request.
  always_comb begin
    upper = req & ({N{1'b1}} << ptr);
    pick  = (|upper) ? upper : req;
    gnt   = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pick[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin sharing of one BRAM port with lock, registered drive and in-order read return
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH,
  parameter int BRAM_DATA_WIDTH = DEF_BRAM_DATA_WIDTH,
  parameter int BYTES_PER_WIDTH = DEF_BYTES_PER_WIDTH,
  parameter int READ_LATENCY    = 1,
  parameter int LOCK_TIMEOUT    = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BYTES_PER_WIDTH-1:0]   req_we,
  input  logic [NUM_REQ*BRAM_DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]                   req_lock,
  output logic [NUM_REQ-1:0]                   gnt,
  output logic [NUM_REQ-1:0]                   rvalid,
  output logic [BRAM_DATA_WIDTH-1:0]           rdata,
  output logic                                 lock_err,
  output logic                                 bram_clk,
  output logic                                 bram_en,
  output logic [BRAM_ADDR_WIDTH-1:0]           bram_addr,
  output logic [BYTES_PER_WIDTH-1:0]           bram_we,
  output logic [BRAM_DATA_WIDTH-1:0]           bram_din,
  input  logic [BRAM_DATA_WIDTH-1:0]           bram_dout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LOCK_TIMER_WIDTH-1:0] TIMEOUT_LAST = LOCK_TIMER_WIDTH'(LOCK_TIMEOUT - 1);

  logic [BRAM_ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [BYTES_PER_WIDTH-1:0] we_a    [NUM_REQ];
  logic [BRAM_DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
    assign we_a[g]    = req_we[g*BYTES_PER_WIDTH +: BYTES_PER_WIDTH];
    assign wdata_a[g] = req_wdata[g*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
  end

  lock_state_e                 state_q, state_d;
  logic [IW-1:0]               owner_q, owner_d;
  logic [LOCK_TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                        lock_err_q, lock_err_d;
  logic [IW-1:0]               ptr_q;

  logic [NUM_REQ-1:0]          rr_gnt;
  logic [IW-1:0]               rr_idx;
  logic                        accept;
  logic [IW-1:0]               acc_idx;
  logic                        sel_lock;
  logic                        is_read;

  logic [READ_LATENCY:0]       tag_vld;
  logic [IW-1:0]               tag_id [READ_LATENCY+1];

  bram_port_arbiter_rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // While locked only the owner may be granted; the round-robin pick is ignored.
  always_comb begin
    gnt = '0;
    if (enable) begin
      if (state_q == LOCKED) begin
        gnt[owner_q] = req[owner_q];
      end else begin
        gnt = rr_gnt;
      end
    end
  end

  assign accept   = |gnt;
  assign acc_idx  = (state_q == LOCKED) ? owner_q : rr_idx;
  assign sel_lock = req_lock[acc_idx];
  assign is_read  = ~|we_a[acc_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q     <= '0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      bram_we   <= '0;
      bram_din  <= '0;
    end else begin
      bram_en <= accept;
      if (accept) begin
        ptr_q     <= IW'(wrap_inc(int'(acc_idx), NUM_REQ));
        bram_addr <= addr_a[acc_idx];
        bram_we   <= we_a[acc_idx];
        bram_din  <= wdata_a[acc_idx];
      end else begin
        bram_we   <= '0;
      end
    end
  end

  // Read tags travel alongside the BRAM latency so returns stay in issue order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) begin
        tag_id[k] <= '0;
      end
    end else begin
      tag_vld   <= {tag_vld[READ_LATENCY-1:0], accept & is_read};
      tag_id[0] <= acc_idx;
      for (int k = 1; k <= READ_LATENCY; k++) begin
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag_vld[READ_LATENCY]) begin
      rvalid[tag_id[READ_LATENCY]] = 1'b1;
    end
  end

  assign rdata    = tag_vld[READ_LATENCY] ? bram_dout : '0;
  assign bram_clk = clk;
  assign lock_err = lock_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= UNLOCKED;
      owner_q    <= '0;
      timer_q    <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Timer counts enabled locked cycles without an owner access; enable low freezes it.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    timer_d    = timer_q;
    lock_err_d = lock_err_q;
    case (state_q)
      UNLOCKED: begin
        if (accept && sel_lock) begin
          state_d = LOCKED;
          owner_d = acc_idx;
          timer_d = '0;
        end
      end
      LOCKED: begin
        if (enable) begin
          if (accept) begin
            timer_d = '0;
            if (!sel_lock) begin
              state_d = UNLOCKED;
            end
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d    = UNLOCKED;
            timer_d    = '0;
            lock_err_d = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

endmodule
